// File: rtl/des_pkg.sv
// Shared DES tables and helpers: permutations, key-schedule rotations, S-boxes.
// Bit numbering follows FIPS 46, so table entry n refers to vector bit [W-n].
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } des_state_e;

    localparam int          BLOCK_W   = 64;
    localparam int          HALF_W    = 32;
    localparam int          KEY_W     = 56;
    localparam int          SUBKEY_W  = 48;
    localparam int          CNT_W     = 5;
    localparam logic [4:0]  LAST_RND  = 5'd16;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Each S-box is 4 rows of 16, indexed by {row, col}.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_ip[63-i] = x[64-IP_TBL[i]];
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_fp[63-i] = x[64-FP_TBL[i]];
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        for (int i = 0; i < 48; i++) perm_e[47-i] = x[32-E_TBL[i]];
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        for (int i = 0; i < 32; i++) perm_p[31-i] = x[32-P_TBL[i]];
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) perm_pc1[55-i] = x[64-PC1_TBL[i]];
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) perm_pc2[47-i] = x[56-PC2_TBL[i]];
    endfunction

    // Right-rotation amount for decryption round rnd (reverse of the encrypt left shifts).
    function automatic logic [1:0] rot_amt(input logic [4:0] rnd);
        case (rnd)
            5'd1:                 rot_amt = 2'd0;
            5'd2, 5'd9, 5'd16:    rot_amt = 2'd1;
            default:              rot_amt = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
        sbox = SBOX[n][{b[5], b[0], b[4:1]}];
    endfunction

endpackage

// File: rtl/des_f.sv
// DES f-function: E-expansion, subkey XOR, S1..S8 substitution, P permutation.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_in,
    input  logic [47:0] k_in,
    output logic [31:0] f_out
);

    logic [47:0] x;
    logic [31:0] s_out;

    assign x = perm_e(r_in) ^ k_in;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s_out[31-4*g -: 4] = sbox(g, x[47-6*g -: 6]);
    end

    assign f_out = perm_p(s_out);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, key schedule run K16..K1.
//   state    | meaning
//   ST_IDLE  | in_ready=1, waiting for a ciphertext/key pair
//   ST_ROUND | round_cnt 1..16 run rounds; round_cnt 17 registers FP result
//   ST_DONE  | out_valid=1, result held until out_ready
module des_decrypt_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    des_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;

    logic [63:0] ip_val;
    logic [55:0] pc1_val;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_val;

    assign ip_val  = perm_ip(in_data);
    assign pc1_val = perm_pc1(in_key);

    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        case (rot_amt(cnt_q))
            2'd1: begin
                c_rot = {c_q[0], c_q[27:1]};
                d_rot = {d_q[0], d_q[27:1]};
            end
            2'd2: begin
                c_rot = {c_q[1:0], c_q[27:2]};
                d_rot = {d_q[1:0], d_q[27:2]};
            end
            default: ;
        endcase
    end

    assign subkey = perm_pc2({c_rot, d_rot});

    des_f u_f (
        .r_in  (r_q),
        .k_in  (subkey),
        .f_out (f_val)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = ip_val;
                    {c_d, d_d} = pc1_val;
                    cnt_d      = 5'd1;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (cnt_q > LAST_RND) begin
                    // Halves swapped before FP: pre-output block is R16||L16.
                    out_data_d  = perm_fp({r_q, l_q});
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    l_d   = r_q;
                    r_d   = l_q ^ f_val;
                    c_d   = c_rot;
                    d_d   = d_rot;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer vectors plus handshake/reset sequences.
module tb_des_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int checks   = 0;
    int failures = 0;

    localparam int EXP_LAT = 17;

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    des_decrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for out_valid after an accept edge; checks latency, in_ready low while busy, data.
    task automatic wait_result(input string name, input logic [63:0] exp_pt);
        int  n = 0;
        bit  ready_seen = 0;
        while (!out_valid && n < 40) begin
            if (in_ready) ready_seen = 1;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(EXP_LAT));
        check({name, " in_ready_busy"}, 64'(ready_seen), 64'd0);
        check({name, " in_ready_done"}, 64'(in_ready), 64'd0);
        check({name, " data"}, out_data, exp_pt);
    endtask

    task automatic accept(input logic [63:0] key, input logic [63:0] ct);
        in_key   = key;
        in_data  = ct;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        in_key   = '0;
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid_after"}, 64'(out_valid), 64'd0);
        check({name, " in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
        vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
        vecs[2] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
        vecs[4] = '{64'h123556789ABDDEF0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
        vecs[5] = '{64'h0F339333EB6C0C72, 64'h0000000000000000, 64'h8787878787878787};
        vecs[6] = '{64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", out_data, 64'd0);

        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].key, vecs[i].ct);
            wait_result($sformatf("vec%0d", i), vecs[i].pt);
            release_out($sformatf("vec%0d", i));
        end

        // Output held while out_ready stays low in DONE.
        begin
            bit held_ok = 1;
            accept(vecs[0].key, vecs[0].ct);
            wait_result("hold", vecs[0].pt);
            out_ready = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (!out_valid || out_data !== vecs[0].pt || in_ready) held_ok = 0;
            end
            check("hold stable", 64'(held_ok), 64'd1);
            release_out("hold");
        end

        // in_valid with other data during ROUND is ignored.
        begin
            in_key = vecs[0].key; in_data = vecs[0].ct; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            in_key = vecs[3].key; in_data = vecs[3].ct; in_valid = 1'b1;
            repeat (4) @(negedge clk);
            in_valid = 1'b0; in_key = '0; in_data = '0;
            begin
                int n = 7;
                while (!out_valid && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                check("ignore latency", 64'(n), 64'(EXP_LAT));
            end
            check("ignore data", out_data, vecs[0].pt);
            release_out("ignore");
        end

        // Reset at round 8 aborts the block; no partial result appears.
        begin
            bit no_valid = 1;
            accept(vecs[0].key, vecs[0].ct);
            repeat (7) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("midrst out_valid", 64'(out_valid), 64'd0);
            check("midrst out_data", out_data, 64'd0);
            check("midrst in_ready", 64'(in_ready), 64'd1);
            repeat (20) begin
                @(negedge clk);
                if (out_valid) no_valid = 0;
            end
            check("midrst no_result", 64'(no_valid), 64'd1);
            accept(vecs[1].key, vecs[1].ct);
            wait_result("post_rst", vecs[1].pt);
            release_out("post_rst");
        end

        // Back-to-back with in_valid held high; second block accepted the cycle after handshake.
        begin
            in_key = vecs[0].key; in_data = vecs[0].ct; in_valid = 1'b1;
            @(negedge clk);
            in_key = vecs[1].key; in_data = vecs[1].ct;
            wait_result("b2b_first", vecs[0].pt);
            out_ready = 1'b1;
            @(negedge clk);
            check("b2b handshake out_valid", 64'(out_valid), 64'd0);
            check("b2b handshake in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b0; in_key = '0; in_data = '0;
            check("b2b accepted", 64'(in_ready), 64'd0);
            wait_result("b2b_second", vecs[1].pt);
            release_out("b2b_second");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
